lsu: RTL and testbench

Load/store unit sitting between the core's memory stage and `dat_mem`: it accepts RV32I byte, halfword and word load/store requests and converts them into word-only, word-aligned accesses on the data memory port (`dat_op = 3'b010`). Sub-word loads are extracted and sign/zero-extended. Sub-word stores are done as read-modify-write. Misaligned or unsupported requests are rejected without touching memory.

---
 rtl/lsu_if.sv | 28 ++
 rtl/lsu.sv | 179 +++++++++++++++++
 tb/tb_lsu.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Core-side request/response and data-memory port signals of the load/store unit.
interface lsu_if;
  logic        req;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] st_dat;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] ld_dat;
  logic [31:0] m_addr;
  logic [31:0] m_w_dat;
  logic [2:0]  m_dat_op;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_r_dat;

  modport slave (
    input  req, is_store, funct3, addr, st_dat, m_r_dat,
    output busy, done, err, ld_dat, m_addr, m_w_dat, m_dat_op, m_read, m_write
  );

  modport master (
    output req, is_store, funct3, addr, st_dat, m_r_dat,
    input  busy, done, err, ld_dat, m_addr, m_w_dat, m_dat_op, m_read, m_write
  );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: turns byte/half/word requests into word-aligned word
// accesses, extending sub-word loads and doing sub-word stores as read-modify-write.
module lsu (
  input  logic   clk,
  input  logic   rst,
  lsu_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    LDRET,
    MERGE,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic [31:0] st_q;
  logic        st_is_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] ld_q;

  logic        req_ok;
  logic        is_sw;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_w_dat;
  logic [31:0] merged;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Width code legality first, then natural alignment for halves and words.
  always_comb begin
    req_ok = 1'b1;
    if (bus.is_store) begin
      if (bus.funct3[2] || (bus.funct3[1:0] == 2'b11)) req_ok = 1'b0;
    end else begin
      if ((bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11)) req_ok = 1'b0;
    end
    if ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) req_ok = 1'b0;
    if ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00)) req_ok = 1'b0;
  end

  assign is_sw = st_is_q && (f3_q == 3'b010);

  always_comb begin
    merged = bus.m_r_dat;
    if (f3_q[0]) begin
      if (addr_q[1]) merged[31:16] = st_q[15:0];
      else           merged[15:0]  = st_q[15:0];
    end else begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = st_q[7:0];
        2'd1:    merged[15:8]  = st_q[7:0];
        2'd2:    merged[23:16] = st_q[7:0];
        default: merged[31:24] = st_q[7:0];
      endcase
    end
  end

  always_comb begin
    m_read  = 1'b0;
    m_write = 1'b0;
    m_w_dat = '0;
    case (state)
      ACC: begin
        if (is_sw) begin
          m_write = 1'b1;
          m_w_dat = st_q;
        end else begin
          m_read = 1'b1;
        end
      end
      MERGE: begin
        m_write = 1'b1;
        m_w_dat = merged;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      st_q    <= '0;
      st_is_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ld_q    <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            addr_q  <= bus.addr;
            f3_q    <= bus.funct3;
            st_q    <= bus.st_dat;
            st_is_q <= bus.is_store;
            busy_q  <= 1'b1;
            if (req_ok) begin
              state <= ACC;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
              if (!bus.is_store) ld_q <= '0;
            end
          end
        end
        ACC: begin
          if (is_sw) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else if (st_is_q) begin
            state <= MERGE;
          end else begin
            state <= LDRET;
          end
        end
        LDRET: begin
          ld_q   <= extract(bus.m_r_dat, f3_q, addr_q[1:0]);
          state  <= DONE;
          done_q <= 1'b1;
        end
        MERGE: begin
          state  <= DONE;
          done_q <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.ld_dat   = ld_q;
  assign bus.m_addr   = {addr_q[31:2], 2'b00};
  assign bus.m_read   = m_read;
  assign bus.m_write  = m_write;
  assign bus.m_w_dat  = m_w_dat;
  assign bus.m_dat_op = (m_read || m_write) ? 3'b010 : 3'b000;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a small synchronous word memory behind the data port.
module tb_lsu;

  logic clk;
  logic rst;
  lsu_if bus ();

  lsu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:15];
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int n_cmp    = 0;
  int n_err    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.m_read) begin
      bus.m_r_dat <= mem[bus.m_addr[5:2]];
      rd_cnt <= rd_cnt + 1;
    end
    if (bus.m_write) begin
      mem[bus.m_addr[5:2]] <= bus.m_w_dat;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat, input logic exp_err,
                        input int exp_rd, input int exp_wr,
                        input logic chk_ld, input logic [31:0] exp_ld);
    int lat;
    int rd0;
    int wr0;
    @(negedge clk);
    bus.req      = 1'b1;
    bus.is_store = st;
    bus.funct3   = f3;
    bus.addr     = a;
    bus.st_dat   = d;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(posedge clk);
    #1 bus.req = 1'b0;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lat++;
      if (bus.done) break;
    end
    chk({tag, " lat"}, lat, exp_lat);
    chk({tag, " err"}, bus.err, exp_err);
    if (chk_ld) chk({tag, " ld"}, bus.ld_dat, exp_ld);
    chk({tag, " rd"}, rd_cnt - rd0, exp_rd);
    chk({tag, " wr"}, wr_cnt - wr0, exp_wr);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int rd0;
    int wr0;
    int d0;
    bus.req      = 1'b0;
    bus.is_store = 1'b0;
    bus.funct3   = 3'b000;
    bus.addr     = '0;
    bus.st_dat   = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst err", bus.err, 0);
    chk("rst rdwr", {bus.m_read, bus.m_write}, 0);
    chk("rst ld", bus.ld_dat, 0);
    chk("rst maddr", bus.m_addr, 0);
    chk("rst wdat", bus.m_w_dat, 0);
    chk("rst op", bus.m_dat_op, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    do_req("sw0",  1, 3'b010, 32'h0, 32'hCAFE_F00D, 2, 0, 0, 1, 0, 0);
    do_req("sw4",  1, 3'b010, 32'h4, 32'h80FF_7F01, 2, 0, 0, 1, 0, 0);
    do_req("lb7",  0, 3'b000, 32'h7, 0, 3, 0, 1, 0, 1, 32'hFFFF_FF80);
    do_req("lbu7", 0, 3'b100, 32'h7, 0, 3, 0, 1, 0, 1, 32'h0000_0080);
    do_req("lh6",  0, 3'b001, 32'h6, 0, 3, 0, 1, 0, 1, 32'hFFFF_80FF);
    do_req("lhu4", 0, 3'b101, 32'h4, 0, 3, 0, 1, 0, 1, 32'h0000_7F01);
    do_req("lb5",  0, 3'b000, 32'h5, 0, 3, 0, 1, 0, 1, 32'h0000_007F);
    do_req("lw4",  0, 3'b010, 32'h4, 0, 3, 0, 1, 0, 1, 32'h80FF_7F01);
    do_req("sw4b", 1, 3'b010, 32'h4, 32'h1122_3344, 2, 0, 0, 1, 1, 32'h80FF_7F01);
    do_req("sb5",  1, 3'b000, 32'h5, 32'h0000_00AB, 3, 0, 1, 1, 1, 32'h80FF_7F01);
    chk("sb5 mem", mem[1], 32'h1122_AB44);
    do_req("sh6",  1, 3'b001, 32'h6, 32'h0000_BEEF, 3, 0, 1, 1, 0, 0);
    chk("sh6 mem", mem[1], 32'hBEEF_AB44);
    do_req("lw4b", 0, 3'b010, 32'h4, 0, 3, 0, 1, 0, 1, 32'hBEEF_AB44);
    do_req("sw8",  1, 3'b010, 32'h8, 32'hDEAD_BEEF, 2, 0, 0, 1, 0, 0);
    do_req("lw8",  0, 3'b010, 32'h8, 0, 3, 0, 1, 0, 1, 32'hDEAD_BEEF);

    do_req("e_sh3",  1, 3'b001, 32'h3, 32'hFFFF_FFFF, 1, 1, 0, 0, 1, 32'hDEAD_BEEF);
    do_req("e_st4",  1, 3'b100, 32'h0, 32'hFFFF_FFFF, 1, 1, 0, 0, 1, 32'hDEAD_BEEF);
    do_req("e_lw2",  0, 3'b010, 32'h2, 0, 1, 1, 0, 0, 1, 32'h0);
    do_req("e_ld3",  0, 3'b011, 32'h0, 0, 1, 1, 0, 0, 1, 32'h0);
    chk("err mem0", mem[0], 32'hCAFE_F00D);
    do_req("lw8b", 0, 3'b010, 32'h8, 0, 3, 0, 1, 0, 1, 32'hDEAD_BEEF);

    // req held high over eight edges: accepted only at edges 0 and 4
    @(negedge clk);
    rd0 = rd_cnt;
    d0  = done_cnt;
    bus.req = 1'b1; bus.is_store = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'h4;
    repeat (8) @(posedge clk);
    #1 bus.req = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold done", done_cnt - d0, 2);
    chk("hold rd", rd_cnt - rd0, 2);
    chk("hold busy", bus.busy, 0);
    chk("hold ld", bus.ld_dat, 32'hBEEF_AB44);

    // req pulsed with a store while a load is in flight
    @(negedge clk);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    d0  = done_cnt;
    bus.req = 1'b1; bus.is_store = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'h8;
    @(posedge clk);
    #1;
    bus.is_store = 1'b1; bus.addr = 32'h0; bus.st_dat = 32'h1234_5678;
    @(posedge clk);
    @(posedge clk);
    #1 bus.req = 1'b0;
    repeat (4) @(negedge clk);
    chk("pulse done", done_cnt - d0, 1);
    chk("pulse rd", rd_cnt - rd0, 1);
    chk("pulse wr", wr_cnt - wr0, 0);
    chk("pulse mem0", mem[0], 32'hCAFE_F00D);
    chk("pulse ld", bus.ld_dat, 32'hDEAD_BEEF);

    // reset while in MERGE of sb 0x55 @0x8
    @(negedge clk);
    wr0 = wr_cnt;
    d0  = done_cnt;
    bus.req = 1'b1; bus.is_store = 1'b1; bus.funct3 = 3'b000; bus.addr = 32'h8;
    bus.st_dat = 32'h0000_0055;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    chk("acc rd", bus.m_read, 1);
    chk("acc op", bus.m_dat_op, 3'b010);
    @(negedge clk);
    chk("mrg wr", bus.m_write, 1);
    chk("mrg wdat", bus.m_w_dat, 32'hDEAD_BE55);
    chk("mrg addr", bus.m_addr, 32'h8);
    #1 rst = 1'b1;
    #1;
    chk("abort wr", bus.m_write, 0);
    chk("abort busy", bus.busy, 0);
    chk("abort ld", bus.ld_dat, 0);
    chk("abort op", bus.m_dat_op, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort wcnt", wr_cnt - wr0, 0);
    chk("abort done", done_cnt - d0, 0);
    chk("abort mem", mem[2], 32'hDEAD_BEEF);
    do_req("lw8c", 0, 3'b010, 32'h8, 0, 3, 0, 1, 0, 1, 32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
